segmented_serial_adder: RTL
===========================

# segmented_serial_adder

Parametrised multi-cycle adder. Operands are shifted in serially and added one SEG-bit segment per clock, with the carry held in a register between segments. The result is presented as a full register and as a bit-selectable readout. It generalises the single-cycle ripple adder test block with configurable width, segment size, a start/busy/done handshake, carry-in/out and an optional subtract mode.

## Interface
Parameters:
- BITS, 64, operand/result width
- SEG, 8, segment width added per cycle; BITS % SEG == 0 required; NSEG = BITS/SEG

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- shift_en  in  1  shift x_bit/y_bit into operands (IDLE only)
- x_bit  in  1  serial operand x, MSB first
- y_bit  in  1  serial operand y, MSB first
- carry_in  in  1  initial carry, sampled with start
- sub  in  1  subtract request, sampled with start (see Configuration)
- start  in  1  begin an add (IDLE only)
- sel  in  $clog2(BITS)  bit index for sum_bit
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result complete
- sum  out  BITS  result register
- carry_out  out  1  final carry
- sum_bit  out  1  sum[sel], combinational from sum register

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. On reset, x, y, sum, carry_out, the carry reg, the segment index, busy and done are all 0.
- IDLE, shift_en=1: x <= {x[BITS-2:0], x_bit}, y <= {y[BITS-2:0], y_bit}.
- IDLE, start=1: carry reg <= carry_in, idx <= 0, state → RUN. start has priority over shift_en in the same cycle; no shift occurs.
- RUN, each cycle: {c, s} = x[idx*SEG +: SEG] + y'[idx*SEG +: SEG] + carry. sum[idx*SEG +: SEG] <= s. carry <= c. idx++.
  - y' = y, or ~y when subtracting.
- After the segment with idx = NSEG-1: carry_out <= c, state → DONE.
- DONE: done=1 for exactly one cycle, then state → IDLE.
- start, shift_en, carry_in and sub are ignored outside IDLE. Operands stay frozen during RUN and DONE.
- sum segments not yet written keep their previous values. sum is valid only from done onward.
- The segment arithmetic is SEG+1 bits wide. Overflow beyond BITS appears only as carry_out.
- sel is out-of-range only for non-power-of-2 BITS. In that case sum_bit = 0.
- Reset mid-RUN aborts the add. Next cycle: IDLE, sum = 0, done is not pulsed.

## Timing
- Start sampled at edge E0. busy is high after E0 through edge E0+NSEG.
- The final segment is written at edge E0+NSEG. done is high during the cycle following E0+NSEG.
- Latency, start to done: NSEG+1 cycles. With SEG=BITS the latency is 2 cycles.
- Back-to-back operation: a new start is accepted in the first IDLE cycle after done. Minimum period is NSEG+2 cycles.
- carry_out and sum are stable from the done cycle until the next start.
- sum_bit has the same latency as sum, plus a combinational mux from sel.

## Configuration
- Macro: SEGMENTED_SERIAL_ADDER_SUB_EN.
- Defined: start with sub=1 uses y' = ~y and initial carry = 1 (carry_in ignored), giving x − y. carry_out=1 means no borrow.
- Undefined: the sub port is present but ignored. The block always adds with carry_in.

## Test plan
BITS=64, SEG=8 unless noted.
- Carry through all segments: shift in x=0xFFFFFFFFFFFFFFFF, y=0x1, start with carry_in=0 → busy for 8 cycles, then done pulse; sum=0, carry_out=1. Repeat with carry_in=1 → sum=1, carry_out=1.
- Known pattern: x=0x0123456789ABCDEF, y=0x1111111111111111 → sum=0x123456789ABCDF00, carry_out=0. sel=8 → sum_bit=1; sel=0 → sum_bit=0.
- Ignored inputs: pulse start and shift_en with random bits during RUN → operands unchanged, done appears only once, 9 cycles after the original start; result matches the unshifted operands.
- Reset mid-run: reset asserted for one cycle after 3 segments → next cycle busy=0, sum=0, carry_out=0, no done pulse; a following add completes normally.
- Subtract, macro defined: x=5, y=7, sub=1 → sum=0xFFFFFFFFFFFFFFFE, carry_out=0. x=7, y=5 → sum=2, carry_out=1. Macro undefined: x=5, y=7, sub=1 → sum=12.
- Degenerate segmenting: SEG=64 → done 2 cycles after start. SEG=1 → done 65 cycles after start; both produce results identical to the known-pattern case.

Source files
------------

// File: rtl/segmented_serial_adder.sv
// segmented_serial_adder: multi-cycle adder that sums one SEG-bit segment per
// clock, holding the carry in a register between segments. Operands are
// shifted in serially (MSB first) while idle. The result is available as a
// full register and through a bit-select readout.
// Optional feature macro: SEGMENTED_SERIAL_ADDER_SUB_EN enables subtract mode
// (x - y computed as x + ~y + 1). Without it the sub input is ignored.
module segmented_serial_adder #(
  parameter int BITS = 64,
  parameter int SEG  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_shift_en,
  input  logic                    i_x_bit,
  input  logic                    i_y_bit,
  input  logic                    i_carry_in,
  input  logic                    i_sub,
  input  logic                    i_start,
  input  logic [$clog2(BITS)-1:0] i_sel,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BITS-1:0]         o_sum,
  output logic                    o_carry_out,
  output logic                    o_sum_bit
);

  localparam int NSEG = BITS / SEG;
  localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          r_state;
  logic [BITS-1:0] r_x;
  logic [BITS-1:0] r_y;
  logic [BITS-1:0] r_sum;
  logic            r_carry;
  logic            r_carryOut;
  logic            r_subMode;
  logic [IDXW-1:0] r_segIdx;
  logic            r_busy;
  logic            r_done;

  logic            w_startCarry;
  logic            w_startSub;
  logic [BITS-1:0] w_yOp;
  logic [BITS-1:0] w_xShift;
  logic [BITS-1:0] w_yShift;
  logic [SEG-1:0]  w_xSeg;
  logic [SEG-1:0]  w_ySeg;
  logic [SEG:0]    w_segResult;
  logic [SEG-1:0]  w_segSum;
  logic            w_segCarry;

`ifdef SEGMENTED_SERIAL_ADDER_SUB_EN
  // A subtract start forces the initial carry to 1 so that ~y + 1 forms -y.
  assign w_startCarry = i_sub ? 1'b1 : i_carry_in;
  assign w_startSub   = i_sub;
`else
  // Subtract support is compiled out; the sub input is accepted but has no effect.
  logic w_unusedSub;
  assign w_unusedSub  = i_sub;
  assign w_startCarry = i_carry_in;
  assign w_startSub   = 1'b0;
`endif

  // The y operand seen by the adder is inverted when a subtraction is running.
  assign w_yOp = r_subMode ? ~r_y : r_y;

  // Bring the active segment down to bit 0 so a fixed slice picks it up.
  assign w_xShift = r_x   >> (int'(r_segIdx) * SEG);
  assign w_yShift = w_yOp >> (int'(r_segIdx) * SEG);
  assign w_xSeg   = w_xShift[SEG-1:0];
  assign w_ySeg   = w_yShift[SEG-1:0];

  // One segment of the sum, one bit wider than a segment to catch the carry.
  assign w_segResult = {1'b0, w_xSeg} + {1'b0, w_ySeg} + {{SEG{1'b0}}, r_carry};
  assign w_segSum    = w_segResult[SEG-1:0];
  assign w_segCarry  = w_segResult[SEG];

  // Control FSM: shift operands while idle, add one segment per RUN cycle,
  // then pulse done for a single cycle before returning to idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      r_subMode  <= 1'b0;
      r_segIdx   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_carry   <= w_startCarry;
            r_subMode <= w_startSub;
            r_segIdx  <= '0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end else if (i_shift_en) begin
            r_x <= {r_x[BITS-2:0], i_x_bit};
            r_y <= {r_y[BITS-2:0], i_y_bit};
          end
        end
        RUN: begin
          r_sum[int'(r_segIdx)*SEG +: SEG] <= w_segSum;
          r_carry  <= w_segCarry;
          r_segIdx <= r_segIdx + IDXW'(1);
          if (r_segIdx == LAST_IDX) begin
            r_carryOut <= w_segCarry;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Bit-select readout of the result; indices past BITS read as zero.
  always_comb begin
    o_sum_bit = 1'b0;
    if (int'(i_sel) < BITS) begin
      o_sum_bit = r_sum[i_sel];
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sum       = r_sum;
  assign o_carry_out = r_carryOut;

endmodule
